gbc_wram_target: RTL

- Wishbone pipelined target that serves the CGB work RAM: 32 KiB, eight 4 KiB banks.
- It is the responder on the memory bus controller's SystemRAM initiator port.
- It decodes CPU addresses $C000-$FDFF, including the echo region, applies the SVBK bank select, and returns ACK/ERR in strict request order at a fixed latency.

---
 rtl/gbc_wram_target.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gbc_wram_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gbc_wram_target                                              |
// | Description : Wishbone pipelined target for the CGB work RAM (32 KiB, 8    |
// |               banks of 4 KiB). Decodes $C000-$FDFF including the echo      |
// |               region, applies SVBK banking, and returns ACK/ERR in order   |
// |               at a fixed ReadLatency.                                      |
// |               Optional macro GBC_WRAM_CLEAR_ON_RESET_EN: zero the whole    |
// |               RAM after reset, stalling the bus while it runs.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gbc_wram_target #(
  parameter     DeviceType  = "Xilinx",
  parameter int ReadLatency = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [7:0]  DAT_ToTarget,
  output logic [7:0]  DAT_ToInitiator,
  output logic        ACK,
  output logic        ERR,
  output logic        RTY,
  output logic        STALL,
  input  logic        IsCGB,
  input  logic [2:0]  WRAMBank
);

  logic                   accept;
  logic                   in_range;
  logic [2:0]             bank;
  logic [14:0]            phys_addr;
  logic                   clearing;
  logic [14:0]            clr_addr;
  logic                   ram_we;
  logic [14:0]            ram_waddr;
  logic [7:0]             ram_wdata;
  logic [7:0]             ram_rd;
  logic [7:0]             rd_data;
  logic [ReadLatency-1:0] vld_q, vld_d;
  logic [ReadLatency-1:0] err_q, err_d;
  logic [ReadLatency-1:0] wr_q, wr_d;
  logic [7:0]             mem [0:32767];

  assign accept = CYC & STB & ~STALL;
  assign RTY    = 1'b0;

  // Address decode; the echo fold only matters for the range test because
  // bits [15:13] never reach the physical address.
  always_comb begin
    in_range  = (ADDR >= 16'hC000) && (ADDR <= 16'hFDFF);
    bank      = IsCGB ? ((WRAMBank == 3'd0) ? 3'd1 : WRAMBank) : 3'd1;
    phys_addr = ADDR[12] ? {bank, ADDR[11:0]} : {3'b000, ADDR[11:0]};
  end

`ifdef GBC_WRAM_CLEAR_ON_RESET_EN
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
  state_t      state_q, state_d;
  logic [14:0] clr_cnt_q, clr_cnt_d;

  // Clear sequencer: sweep every physical address once, then go ready.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 15'd1;
      if (clr_cnt_q == 15'h7FFF) state_d = ST_READY;
    end
  end

  // Clear sequencer state; reset restarts the sweep from address 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= 15'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Gated by RST so the bus sees STALL=0 while reset is held.
  assign clearing = (state_q == ST_CLEAR) && RST;
  assign clr_addr = clr_cnt_q;
  assign STALL    = clearing;
`else
  assign clearing = 1'b0;
  assign clr_addr = 15'd0;
  assign STALL    = 1'b0;
`endif

  // Single RAM write port shared between bus writes and the clear sweep.
  always_comb begin
    ram_we    = accept & WE & in_range;
    ram_waddr = phys_addr;
    ram_wdata = DAT_ToTarget;
    if (clearing) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = 8'h00;
    end
  end

  generate
    if (DeviceType == "Xilinx") begin : g_ram_read_first
      logic [7:0] ram_rd_q;
      // Read-first block RAM; a write lands one edge before any later read.
      always_ff @(posedge CLK) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rd_q <= mem[phys_addr];
      end
      assign ram_rd = ram_rd_q;
    end else begin : g_ram_reg_addr
      logic [14:0] rd_addr_q;
      // Registered-address RAM style used by other vendors' inference.
      always_ff @(posedge CLK) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rd_addr_q <= phys_addr;
      end
      assign ram_rd = mem[rd_addr_q];
    end
  endgenerate

  // Response pipeline: shift {valid, isErr, isWrite}; CYC low flushes it.
  always_comb begin
    vld_d[0] = accept;
    err_d[0] = ~in_range;
    wr_d[0]  = WE;
    for (int i = 1; i < ReadLatency; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      wr_d[i]  = wr_q[i-1];
    end
    if (!CYC) vld_d = '0;
  end

  // Response pipeline registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= '0;
      err_q <= '0;
      wr_q  <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      wr_q  <= wr_d;
    end
  end

  generate
    if (ReadLatency == 1) begin : g_dat_direct
      assign rd_data = ram_rd;
    end else begin : g_dat_shift
      logic [7:0] dat_q [ReadLatency-1];
      logic [7:0] dat_d [ReadLatency-1];
      // Read data follows its request down the pipeline.
      always_comb begin
        dat_d[0] = ram_rd;
        for (int i = 1; i < ReadLatency - 1; i++) dat_d[i] = dat_q[i-1];
      end
      // Read data delay registers.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int i = 0; i < ReadLatency - 1; i++) dat_q[i] <= 8'h00;
        end else begin
          for (int i = 0; i < ReadLatency - 1; i++) dat_q[i] <= dat_d[i];
        end
      end
      assign rd_data = dat_q[ReadLatency-2];
    end
  endgenerate

  // CYC gating hides a response that falls due in the abort cycle itself.
  assign ACK             = vld_q[ReadLatency-1] & ~err_q[ReadLatency-1] & CYC;
  assign ERR             = vld_q[ReadLatency-1] &  err_q[ReadLatency-1] & CYC;
  assign DAT_ToInitiator = (ACK & ~wr_q[ReadLatency-1]) ? rd_data : 8'h00;

endmodule
`default_nettype wire
